// File: rtl/instr_fetch.sv
// MIPS fetch stage: owns the PC, issues one word read at a time on a ready-based bus and
// holds each fetched instruction with its PC until downstream accepts or a flush redirects.
module instr_fetch #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  input  logic        flush,
  input  logic [31:0] flush_target
);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold,
    StDrain
  } state_e;

  state_e      state_q;
  logic [31:0] pc_reg_q;
  logic [31:0] pc_pend_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic        out_valid_q;
  logic        imem_req_q;

  logic [31:0] flush_pc;
  logic [31:0] branch_off;
  logic [31:0] next_pc;

  assign flush_pc   = {flush_target[31:2], 2'b00};
  assign pc_plus4   = pc_q + 32'd4;
  assign branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  assign imem_req   = imem_req_q;
  assign imem_addr  = {pc_reg_q[31:2], 2'b00};
  assign instr      = instr_q;
  assign opcode     = instr_q[31:26];
  assign pc         = pc_q;
  assign out_valid  = out_valid_q;

  // Jump wins over a taken branch; both are relative to the held instruction.
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    end else if (branch && zero) begin
      next_pc = pc_plus4 + branch_off;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pc_reg_q    <= PC_RESET;
      pc_pend_q   <= PC_RESET;
      instr_q     <= 32'h0;
      pc_q        <= PC_RESET;
      out_valid_q <= 1'b0;
      imem_req_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (flush) begin
            pc_reg_q <= flush_pc;
          end
          imem_req_q <= 1'b1;
          state_q    <= StFetch;
        end

        StFetch: begin
          if (flush) begin
            if (imem_ready) begin
              pc_reg_q <= flush_pc;
            end else begin
              // The request cannot be withdrawn: park the redirect until it completes.
              pc_pend_q <= flush_pc;
              state_q   <= StDrain;
            end
          end else if (imem_ready) begin
            instr_q     <= imem_rdata;
            pc_q        <= imem_addr;
            out_valid_q <= 1'b1;
            imem_req_q  <= 1'b0;
            state_q     <= StHold;
          end
        end

        StDrain: begin
          if (imem_ready) begin
            pc_reg_q <= flush ? flush_pc : pc_pend_q;
            state_q  <= StFetch;
          end else if (flush) begin
            pc_pend_q <= flush_pc;
          end
        end

        StHold: begin
          if (flush) begin
            out_valid_q <= 1'b0;
            pc_reg_q    <= flush_pc;
            imem_req_q  <= 1'b1;
            state_q     <= StFetch;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            pc_reg_q    <= next_pc;
            imem_req_q  <= 1'b1;
            state_q     <= StFetch;
          end
        end

        default: begin
          state_q    <= StIdle;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed table of redirect cases, hand sequences for flush/reset
// corners, then a randomized run against a transaction-level model of the fetch stream.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_ready = 1'b0;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        branch = 1'b0;
  logic        zero = 1'b0;
  logic        jump = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_target = 32'h0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instr_fetch #(.PC_RESET(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ready   (imem_ready),
    .instr        (instr),
    .opcode       (opcode),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .branch       (branch),
    .zero         (zero),
    .jump         (jump),
    .flush        (flush),
    .flush_target (flush_target)
  );

  typedef struct {
    logic [31:0] at_pc;
    logic [31:0] word;
    logic        br;
    logic        zr;
    logic        jp;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_req"}, 32'(imem_req), 32'h0);
    chk({nm, "_addr"}, imem_addr, 32'h0);
    chk({nm, "_instr"}, instr, 32'h0);
    chk({nm, "_opcode"}, 32'(opcode), 32'h0);
    chk({nm, "_pc"}, pc, 32'h0);
    chk({nm, "_pcp4"}, pc_plus4, 32'h4);
    chk({nm, "_valid"}, 32'(out_valid), 32'h0);
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] w,
                                           input logic br, input logic zr, input logic jp);
    logic [31:0] seq;
    int          off;
    seq = p + 32'd4;
    if (jp) return {seq[31:28], w[25:0], 2'b00};
    if (br && zr) begin
      off = $signed(w[15:0]);
      return seq + 32'(off * 4);
    end
    return seq;
  endfunction

  logic        m_valid, m_discard, fresh, q, r;
  logic [31:0] m_addr, m_pc, prev_addr, a0;

  initial begin
    vecs[0] = '{32'h0000_0010, 32'h1109_FFFF, 1'b1, 1'b1, 1'b0, 32'h0000_0010};
    vecs[1] = '{32'h0000_0010, 32'h1109_FFFF, 1'b1, 1'b0, 1'b0, 32'h0000_0014};
    vecs[2] = '{32'h3000_0000, 32'h0800_0040, 1'b1, 1'b1, 1'b1, 32'h3000_0100};
    vecs[3] = '{32'h0000_0100, 32'h1000_0003, 1'b1, 1'b1, 1'b0, 32'h0000_0110};
    vecs[4] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
    vecs[5] = '{32'hFFFF_FFFC, 32'h0BFF_FFFF, 1'b0, 1'b0, 1'b1, 32'h0FFF_FFFC};
    vecs[6] = '{32'h7FFF_FFF0, 32'h1000_7FFF, 1'b1, 1'b1, 1'b0, 32'h8001_FFF0};
    vecs[7] = '{32'h0000_1000, 32'h1000_FFFF, 1'b0, 1'b1, 1'b0, 32'h0000_1004};

    // Reset and first fetch
    repeat (2) @(posedge clk);
    #1;
    chk_reset("por");
    rst_n = 1'b1;
    chk("idle_req", 32'(imem_req), 32'h0);
    step();
    chk("first_req", 32'(imem_req), 32'h1);
    chk("first_addr", imem_addr, 32'h0);
    chk("first_valid", 32'(out_valid), 32'h0);
    imem_ready = 1'b1;
    imem_rdata = 32'h8C08_0004;
    step();
    imem_ready = 1'b0;
    chk("first_out_valid", 32'(out_valid), 32'h1);
    chk("first_opcode", 32'(opcode), 32'h23);
    chk("first_instr", instr, 32'h8C08_0004);
    chk("first_pc", pc, 32'h0);
    chk("first_pcp4", pc_plus4, 32'h4);

    // Backpressure in HOLD
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_instr", instr, 32'h8C08_0004);
      chk("bp_pc", pc, 32'h0);
      chk("bp_req", 32'(imem_req), 32'h0);
      chk("bp_valid", 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("seq_addr", imem_addr, 32'h4);
    chk("seq_req", 32'(imem_req), 32'h1);
    chk("seq_valid", 32'(out_valid), 32'h0);

    // Redirect table: flush to the vector PC (coinciding with ready), fetch, accept
    for (int i = 0; i < 8; i++) begin
      flush = 1'b1;
      flush_target = vecs[i].at_pc;
      imem_ready = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      step();
      flush = 1'b0;
      imem_ready = 1'b0;
      chk("tbl_flush_req", 32'(imem_req), 32'h1);
      chk("tbl_flush_addr", imem_addr, vecs[i].at_pc);
      chk("tbl_flush_valid", 32'(out_valid), 32'h0);
      imem_ready = 1'b1;
      imem_rdata = vecs[i].word;
      step();
      imem_ready = 1'b0;
      chk("tbl_valid", 32'(out_valid), 32'h1);
      chk("tbl_instr", instr, vecs[i].word);
      chk("tbl_pc", pc, vecs[i].at_pc);
      chk("tbl_opcode", 32'(opcode), 32'(vecs[i].word[31:26]));
      chk("tbl_pcp4", pc_plus4, vecs[i].at_pc + 32'd4);
      branch = vecs[i].br;
      zero = vecs[i].zr;
      jump = vecs[i].jp;
      out_ready = 1'b1;
      step();
      {branch, zero, jump, out_ready} = 4'b0;
      chk("tbl_next_addr", imem_addr, vecs[i].exp_next);
      chk("tbl_next_req", 32'(imem_req), 32'h1);
      chk("tbl_next_valid", 32'(out_valid), 32'h0);
    end

    // Flush during an outstanding fetch
    a0 = vecs[7].exp_next;
    flush = 1'b1;
    flush_target = 32'h0000_0203;
    step();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("drain_req", 32'(imem_req), 32'h1);
      chk("drain_addr", imem_addr, a0);
      chk("drain_valid", 32'(out_valid), 32'h0);
      if (i < 2) step();
    end
    imem_ready = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    step();
    imem_ready = 1'b0;
    chk("drain_done_valid", 32'(out_valid), 32'h0);
    chk("drain_done_req", 32'(imem_req), 32'h1);
    chk("drain_done_addr", imem_addr, 32'h0000_0200);

    // Second flush while draining overrides the first
    flush = 1'b1;
    flush_target = 32'h0000_0300;
    step();
    chk("ovr_addr_a", imem_addr, 32'h0000_0200);
    flush_target = 32'h0000_0504;
    step();
    flush = 1'b0;
    chk("ovr_addr_b", imem_addr, 32'h0000_0200);
    imem_ready = 1'b1;
    step();
    chk("ovr_valid", 32'(out_valid), 32'h0);
    chk("ovr_new_addr", imem_addr, 32'h0000_0504);
    imem_rdata = 32'h0C00_0001;
    step();
    imem_ready = 1'b0;
    chk("ovr_deliver_valid", 32'(out_valid), 32'h1);
    chk("ovr_deliver_pc", pc, 32'h0000_0504);
    chk("ovr_deliver_instr", instr, 32'h0C00_0001);

    // Flush beats out_ready in HOLD
    flush = 1'b1;
    flush_target = 32'h0000_0040;
    out_ready = 1'b1;
    jump = 1'b1;
    step();
    {flush, out_ready, jump} = 3'b0;
    chk("hold_flush_valid", 32'(out_valid), 32'h0);
    chk("hold_flush_addr", imem_addr, 32'h0000_0040);
    chk("hold_flush_req", 32'(imem_req), 32'h1);

    // Asynchronous reset in HOLD
    imem_ready = 1'b1;
    imem_rdata = 32'h1234_5678;
    step();
    imem_ready = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 32'h1);
    #3 rst_n = 1'b0;
    #1 chk_reset("rst_hold");
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_hold_idle", 32'(imem_req), 32'h0);
    step();
    chk("rst_hold_req", 32'(imem_req), 32'h1);
    chk("rst_hold_addr", imem_addr, 32'h0);

    // Asynchronous reset in DRAIN
    flush = 1'b1;
    flush_target = 32'h0000_0080;
    step();
    flush = 1'b0;
    #3 rst_n = 1'b0;
    #1 chk_reset("rst_drain");
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_drain_idle", 32'(imem_req), 32'h0);
    step();
    chk("rst_drain_req", 32'(imem_req), 32'h1);
    chk("rst_drain_addr", imem_addr, 32'h0);

    // Randomized run against the fetch-stream model
    m_valid   = 1'b0;
    m_discard = 1'b0;
    m_addr    = 32'h0;
    m_pc      = 32'h0;
    fresh     = 1'b1;
    prev_addr = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_valid", 32'(out_valid), 32'(m_valid));
      chk("rnd_req", 32'(imem_req), 32'(!m_valid));
      if (m_valid) begin
        chk("rnd_pc", pc, m_pc);
        chk("rnd_instr", instr, memf(m_pc));
        chk("rnd_pcp4", pc_plus4, m_pc + 32'd4);
      end
      if (imem_req) chk("rnd_addr", imem_addr, fresh ? m_addr : prev_addr);

      q = imem_req;
      r = imem_req && ($urandom_range(0, 1) == 0);
      imem_ready   = r;
      imem_rdata   = r ? memf(imem_addr) : $urandom;
      flush        = ($urandom_range(0, 11) == 0);
      flush_target = $urandom;
      out_ready    = ($urandom_range(0, 2) != 0);
      branch       = $urandom_range(0, 1) == 1;
      zero         = $urandom_range(0, 1) == 1;
      jump         = ($urandom_range(0, 3) == 0);

      if (flush) begin
        m_addr    = {flush_target[31:2], 2'b00};
        m_valid   = 1'b0;
        m_discard = q && !r;
      end else if (q && r) begin
        if (m_discard) begin
          m_discard = 1'b0;
        end else begin
          m_valid = 1'b1;
          m_pc    = m_addr;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
        m_addr  = ref_next(m_pc, memf(m_pc), branch, zero, jump);
      end
      fresh     = !q || r;
      prev_addr = imem_addr;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
